// File: rtl/ccff_pkg.sv
// Shared types and helpers for the configuration-chain loader.
// Holds the loader state encoding and the counter sizing rule.
package ccff_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } ccff_state_t;

    // Bits needed to count from 0 up to and including n.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/ccff_rb_packer.sv
// Collects the bits leaving the configuration chain and packs them MSB-first
// into readback words, flushing a zero-filled partial word at the end of a pass.
module ccff_rb_packer #(
    parameter int WORD_W = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              clear,
    input  logic              sample,
    input  logic              last,
    input  logic              tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid
);
    import ccff_pkg::*;

    localparam int PW = cnt_width(WORD_W);
    localparam logic [WORD_W-1:0] MSB_ONE = {1'b1, {(WORD_W-1){1'b0}}};

    logic [WORD_W-1:0] acc;
    logic [WORD_W-1:0] acc_next;
    logic [PW-1:0]     pos;
    logic              word_full;

    // Each sampled bit lands at its final position, so a short word is
    // already left-aligned with zeros below it when it is flushed.
    always_comb begin
        acc_next = acc;
        if (tail) begin
            acc_next = acc | (MSB_ONE >> pos);
        end
    end

    assign word_full = (pos == PW'(WORD_W - 1)) || last;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            acc      <= '0;
            pos      <= '0;
            rb_data  <= '0;
            rb_valid <= 1'b0;
        end else begin
            rb_valid <= 1'b0;
            if (clear) begin
                acc <= '0;
                pos <= '0;
            end else if (sample) begin
                if (word_full) begin
                    rb_data  <= acc_next;
                    rb_valid <= 1'b1;
                    acc      <= '0;
                    pos      <= '0;
                end else begin
                    acc <= acc_next;
                    pos <= pos + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/ccff_loader.sv
// Streams a bitstream of BS_LGT bits MSB-first into a configuration flip-flop
// chain while reading back the previous chain contents as packed words.
module ccff_loader #(
    parameter int BS_LGT = 8387,
    parameter int WORD_W = 8
) (
    input  logic              prog_clk,
    input  logic              pReset,
    input  logic              start,
    input  logic [WORD_W-1:0] bs_data,
    input  logic              bs_valid,
    output logic              bs_ready,
    output logic              ccff_head,
    output logic              shift_en,
    input  logic              ccff_tail,
    output logic [WORD_W-1:0] rb_data,
    output logic              rb_valid,
    output logic              busy,
    output logic              done
);
    import ccff_pkg::*;

    localparam int CW = cnt_width(BS_LGT);
    localparam int BW = cnt_width(WORD_W);
    localparam logic [CW-1:0] LAST_BIT = CW'(BS_LGT);
    localparam logic [31:0]   TOTAL    = BS_LGT;

    ccff_state_t       state;
    ccff_state_t       state_next;
    logic [CW-1:0]     bit_cnt;
    logic [WORD_W-1:0] buf_word;
    logic [BW-1:0]     buf_cnt;
    logic [31:0]       committed;
    logic              enter_load;
    logic              all_issued;
    logic              more_needed;
    logic              issue;
    logic              accept;

    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // bit_cnt counts bits already presented on ccff_head; a new word is only
    // wanted while issued plus buffered bits fall short of the chain length.
    always_comb begin
        state_next  = state;
        all_issued  = (bit_cnt == LAST_BIT);
        committed   = 32'(bit_cnt) + 32'(buf_cnt);
        more_needed = (committed < TOTAL);
        issue       = 1'b0;
        bs_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = LOAD;
            end
            LOAD: begin
                busy     = 1'b1;
                issue    = (buf_cnt != '0) && !all_issued;
                bs_ready = (buf_cnt <= BW'(1)) && more_needed;
                if (all_issued) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_next = LOAD;
            end
            default: state_next = IDLE;
        endcase
        enter_load = (state != LOAD) && (state_next == LOAD);
        accept     = bs_valid && bs_ready;
    end

    // A word arriving as the last buffered bit leaves keeps shifting gapless;
    // bits of the final word beyond the chain length are dropped.
    always_ff @(posedge prog_clk) begin
        if (pReset) begin
            bit_cnt   <= '0;
            buf_word  <= '0;
            buf_cnt   <= '0;
            ccff_head <= 1'b0;
            shift_en  <= 1'b0;
        end else if (enter_load) begin
            bit_cnt  <= '0;
            buf_word <= '0;
            buf_cnt  <= '0;
            shift_en <= 1'b0;
        end else begin
            shift_en <= issue;
            if (issue) begin
                ccff_head <= buf_word[WORD_W-1];
                bit_cnt   <= bit_cnt + 1'b1;
            end
            if (accept) begin
                buf_word <= bs_data;
                buf_cnt  <= BW'(WORD_W);
            end else if (issue) begin
                buf_word <= buf_word << 1;
                buf_cnt  <= buf_cnt - 1'b1;
            end else if (all_issued) begin
                buf_word <= '0;
                buf_cnt  <= '0;
            end
        end
    end

    ccff_rb_packer #(
        .WORD_W (WORD_W)
    ) u_packer (
        .prog_clk (prog_clk),
        .pReset   (pReset),
        .clear    (enter_load),
        .sample   (shift_en),
        .last     (shift_en && all_issued),
        .tail     (ccff_tail),
        .rb_data  (rb_data),
        .rb_valid (rb_valid)
    );

endmodule

// File: tb/tb_ccff_loader.sv
// Scoreboard bench for ccff_loader: a 20-bit and a 16-bit instance, each with
// a behavioural chain model, driven by directed passes from one initial block.
module tb_ccff_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_start, a_valid, a_ready, a_head, a_sen, a_tail, a_rbv, a_busy, a_done;
    logic [7:0]  a_data, a_rb;
    logic        a_load;
    logic [19:0] a_pre, a_chain;

    logic        b_rst, b_start, b_valid, b_ready, b_head, b_sen, b_tail, b_rbv, b_busy, b_done;
    logic [7:0]  b_data, b_rb;
    logic        b_load;
    logic [15:0] b_pre, b_chain;

    ccff_loader #(.BS_LGT(20), .WORD_W(8)) dut_a (
        .prog_clk (clk),     .pReset   (a_rst),  .start    (a_start),
        .bs_data  (a_data),  .bs_valid (a_valid), .bs_ready (a_ready),
        .ccff_head(a_head),  .shift_en (a_sen),  .ccff_tail(a_tail),
        .rb_data  (a_rb),    .rb_valid (a_rbv),  .busy     (a_busy),
        .done     (a_done)
    );

    ccff_loader #(.BS_LGT(16), .WORD_W(8)) dut_b (
        .prog_clk (clk),     .pReset   (b_rst),  .start    (b_start),
        .bs_data  (b_data),  .bs_valid (b_valid), .bs_ready (b_ready),
        .ccff_head(b_head),  .shift_en (b_sen),  .ccff_tail(b_tail),
        .rb_data  (b_rb),    .rb_valid (b_rbv),  .busy     (b_busy),
        .done     (b_done)
    );

    // Behavioural configuration chains: shift on edges where shift_en is high.
    always @(posedge clk) begin
        if (a_load) a_chain <= a_pre;
        else if (a_sen) a_chain <= {a_chain[18:0], a_head};
    end
    assign a_tail = a_chain[19];

    always @(posedge clk) begin
        if (b_load) b_chain <= b_pre;
        else if (b_sen) b_chain <= {b_chain[14:0], b_head};
    end
    assign b_tail = b_chain[15];

    bit [7:0]    word_q[$];
    bit          bit_q[$];
    bit [7:0]    rb_q[$];
    int          n_assert = 0;
    int          n_fail = 0;
    int          cyc, shifts, low_busy, rb_count, done_cyc, accepted, pushed, gap_left, gap_cfg, bs;
    bit          sel;
    logic [31:0] head_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic setIn(input logic v, input logic [7:0] d);
        if (sel) begin b_valid = v; b_data = d; end
        else begin a_valid = v; a_data = d; end
    endtask

    task automatic setStart(input logic v);
        if (sel) b_start = v;
        else a_start = v;
    endtask

    task automatic checkOutput();
        logic sen, head, rbv, busy, done;
        logic [7:0] rb;
        sen  = sel ? b_sen  : a_sen;
        head = sel ? b_head : a_head;
        rbv  = sel ? b_rbv  : a_rbv;
        busy = sel ? b_busy : a_busy;
        done = sel ? b_done : a_done;
        rb   = sel ? b_rb   : a_rb;
        cyc++;
        if (sen) begin
            shifts++;
            head_acc = {head_acc[30:0], head};
            check("expected_bit_available", 32'(bit_q.size() != 0), 32'd1);
            if (bit_q.size() != 0) check("head_bit", 32'(head), 32'(bit_q.pop_front()));
        end else if (busy) begin
            low_busy++;
        end
        if (rbv) begin
            rb_count++;
            check("expected_rb_available", 32'(rb_q.size() != 0), 32'd1);
            if (rb_q.size() != 0) check("rb_data", 32'(rb), 32'(rb_q.pop_front()));
        end
        if (done && done_cyc == 0) done_cyc = cyc;
    endtask

    // Offers queued words; once the first word is taken, an optional gap holds
    // bs_valid low for gap_cfg cycles while the DUT is ready for the next one.
    task automatic applyStimulus();
        logic ready, v;
        logic [7:0] d, w;
        ready = sel ? b_ready : a_ready;
        v = 1'b0;
        d = 8'h00;
        if (word_q.size() != 0) begin
            if (ready && gap_left > 0) gap_left--;
            else begin v = 1'b1; d = word_q[0]; end
        end
        setIn(v, d);
        if (v && ready) begin
            w = word_q.pop_front();
            accepted++;
            for (int i = 0; i < 8; i++) begin
                if (pushed < bs) begin
                    bit_q.push_back(w[7]);
                    pushed++;
                end
                w = w << 1;
            end
            if (accepted == 1) gap_left = gap_cfg;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput();
        applyStimulus();
    endtask

    task automatic resetCounters(input int gap);
        cyc = 0; shifts = 0; low_busy = 0; rb_count = 0; done_cyc = 0;
        accepted = 0; pushed = 0; gap_left = 0; gap_cfg = gap; head_acc = '0;
        bs = sel ? 16 : 20;
    endtask

    task automatic checkIdleOutputs();
        check("idle_bs_ready",  32'(sel ? b_ready : a_ready), 32'd0);
        check("idle_ccff_head", 32'(sel ? b_head  : a_head),  32'd0);
        check("idle_shift_en",  32'(sel ? b_sen   : a_sen),   32'd0);
        check("idle_rb_data",   32'(sel ? b_rb    : a_rb),    32'd0);
        check("idle_rb_valid",  32'(sel ? b_rbv   : a_rbv),   32'd0);
        check("idle_busy",      32'(sel ? b_busy  : a_busy),  32'd0);
        check("idle_done",      32'(sel ? b_done  : a_done),  32'd0);
    endtask

    task automatic runPass(input bit [7:0] w0, input bit [7:0] w1, input bit [7:0] w2, input int nw,
                           input int gap, input logic [31:0] exp_bits, input int exp_done,
                           input int exp_low, input bit mid_start,
                           input bit [7:0] r0, input bit [7:0] r1, input bit [7:0] r2, input int nrb);
        word_q.delete(); bit_q.delete(); rb_q.delete();
        word_q.push_back(w0);
        word_q.push_back(w1);
        if (nw == 3) word_q.push_back(w2);
        word_q.push_back(8'h99);
        rb_q.push_back(r0);
        rb_q.push_back(r1);
        if (nrb == 3) rb_q.push_back(r2);
        resetCounters(gap);
        setStart(1'b1);
        for (int k = 0; k < 300 && done_cyc == 0; k++) begin
            tick();
            setStart(mid_start && cyc == 5);
            if (cyc == 3) check("busy_in_load", 32'(sel ? b_busy : a_busy), 32'd1);
        end
        check("done_seen", 32'(done_cyc != 0), 32'd1);
        repeat (4) tick();
        check("bit_sequence",   head_acc & ((32'd1 << bs) - 32'd1), exp_bits);
        check("shift_count",    32'(shifts),   32'(bs));
        check("done_cycle",     32'(done_cyc), 32'(exp_done));
        check("stall_cycles",   32'(low_busy), 32'(exp_low));
        check("words_accepted", 32'(accepted), 32'(nw));
        check("rb_valid_count", 32'(rb_count), 32'(nrb));
        check("done_hold",      32'(sel ? b_done : a_done),   32'd1);
        check("ready_in_done",  32'(sel ? b_ready : a_ready), 32'd0);
        word_q.delete();
        setIn(1'b0, 8'h00);
    endtask

    initial begin
        a_rst = 1'b1; a_start = 1'b0; a_valid = 1'b0; a_data = 8'h00; a_load = 1'b1; a_pre = 20'hFFFFF;
        b_rst = 1'b1; b_start = 1'b0; b_valid = 1'b0; b_data = 8'h00; b_load = 1'b1; b_pre = 16'hBEEF;
        sel = 1'b0;
        resetCounters(0);
        repeat (2) tick();
        checkIdleOutputs();
        sel = 1'b1;
        checkIdleOutputs();
        sel = 1'b0;
        a_rst = 1'b0; b_rst = 1'b0; a_load = 1'b0; b_load = 1'b0;
        tick();

        $display("[TB] 20-bit pass, gapless, chain preloaded with all ones");
        runPass(8'hA5, 8'h3C, 8'hF0, 3, 0, 32'hA53CF, 23, 2, 1'b0, 8'hFF, 8'hFF, 8'hF0, 3);

        $display("[TB] 20-bit pass from DONE with a 3-cycle valid gap");
        runPass(8'hA5, 8'h3C, 8'hF0, 3, 3, 32'hA53CF, 26, 5, 1'b0, 8'hA5, 8'h3C, 8'hF0, 3);

        $display("[TB] 20-bit pass aborted by reset after 10 bits");
        word_q.delete(); bit_q.delete(); rb_q.delete();
        word_q.push_back(8'hA5); word_q.push_back(8'h3C); word_q.push_back(8'hF0);
        rb_q.push_back(8'hA5);
        resetCounters(0);
        setStart(1'b1);
        for (int k = 0; k < 100 && shifts < 10; k++) begin
            tick();
            setStart(1'b0);
        end
        check("abort_after_10_bits", 32'(shifts), 32'd10);
        word_q.delete();
        a_rst = 1'b1;
        tick();
        checkIdleOutputs();
        check("abort_rb_consumed", 32'(rb_q.size()), 32'd0);
        a_rst = 1'b0;
        bit_q.delete();
        repeat (3) tick();
        check("abort_no_done", 32'(a_done), 32'd0);
        check("abort_rb_count", 32'(rb_count), 32'd1);
        a_load = 1'b1; a_pre = 20'h12345;
        tick();
        a_load = 1'b0;

        $display("[TB] 20-bit pass after abort restarts from the first bit");
        runPass(8'hA5, 8'h3C, 8'hF0, 3, 0, 32'hA53CF, 23, 2, 1'b0, 8'h12, 8'h34, 8'h50, 3);

        $display("[TB] 16-bit passes: start ignored in LOAD, start in DONE restarts");
        sel = 1'b1;
        runPass(8'h5A, 8'hC3, 8'h00, 2, 0, 32'h5AC3, 19, 2, 1'b1, 8'hBE, 8'hEF, 8'h00, 2);
        runPass(8'h5A, 8'hC3, 8'h00, 2, 0, 32'h5AC3, 19, 2, 1'b0, 8'h5A, 8'hC3, 8'h00, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
